// File: rtl/circ_buf_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : circ_buf_seq_pkg
// Brief    : Shared defaults, FSM encoding and pointer helper for circ_buf_seq.
// Revision : 1.0 - initial release
// ============================================================================
package circ_buf_seq_pkg;

    localparam int c_DATA_W  = 16;
    localparam int c_DEPTH   = 1536;
    localparam int c_SEQ_LEN = 1021;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_t;

    // Ring pointers need not be a power of two, so wrap explicitly.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram_sync.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_sync
// Brief    : DEPTH x DATA_W RAM, one write port, one synchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_sync #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/circ_buf_seq.sv
`default_nettype none
// ============================================================================
// Module   : circ_buf_seq
// Brief    : Circular sample buffer streaming the newest SEQ_LEN samples.
// Revision : 1.0 - initial release
// ============================================================================
module circ_buf_seq
    import circ_buf_seq_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int DEPTH   = c_DEPTH,
    parameter int SEQ_LEN = c_SEQ_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wrt_smpl,
    input  logic [DATA_W-1:0] new_smpl,
    output logic [DATA_W-1:0] smpl_out,
    output logic              sequencing,
    output logic              primed,
    output logic              full,
    output logic              overrun
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_SEQ_CNT   = CNT_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_LAST_RD   = CNT_W'(SEQ_LEN - 1);

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wptr, w_wptr_nxt;
    logic [ADDR_W-1:0] r_raddr, w_raddr_nxt, w_start;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [CNT_W-1:0]  r_rcnt, w_rcnt_nxt;
    logic              r_pending, w_pending_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              r_seq;
    logic              w_wr, w_trig, w_rd_en;
    logic [31:0]       w_start_sum;
    logic [DATA_W-1:0] w_rdata;

    assign w_wr        = wrt_smpl & ~clr;
    assign w_wptr_nxt  = w_wr ? ADDR_W'(wrap_inc(32'(r_wptr), 32'(DEPTH))) : r_wptr;
    assign w_count_nxt = (w_wr && (r_count != c_DEPTH_CNT)) ? r_count + CNT_W'(1) : r_count;
    assign w_trig      = w_wr && (w_count_nxt >= c_SEQ_CNT);
    assign w_rd_en     = (r_state == ST_SEQ);

    // Window start: the newest SEQ_LEN samples, counted back from the post-write pointer.
    assign w_start_sum = 32'(w_wptr_nxt) + 32'(DEPTH - SEQ_LEN);
    assign w_start     = (w_start_sum >= 32'(DEPTH)) ? ADDR_W'(w_start_sum - 32'(DEPTH))
                                                     : ADDR_W'(w_start_sum);

    always_comb begin
        w_state_nxt   = r_state;
        w_raddr_nxt   = r_raddr;
        w_rcnt_nxt    = r_rcnt;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        case (r_state)
            ST_IDLE: begin
                if (w_trig || r_pending) begin
                    w_state_nxt   = ST_SEQ;
                    w_raddr_nxt   = w_start;
                    w_rcnt_nxt    = '0;
                    w_pending_nxt = 1'b0;
                end
            end
            ST_SEQ: begin
                w_raddr_nxt = ADDR_W'(wrap_inc(32'(r_raddr), 32'(DEPTH)));
                w_rcnt_nxt  = r_rcnt + CNT_W'(1);
                if (r_rcnt == c_LAST_RD) begin
                    w_state_nxt = ST_IDLE;
                end
                // Only one follow-on sequence can be queued; a second is lost.
                if (w_trig) begin
                    if (r_pending) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_pending_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wptr    <= '0;
            r_raddr   <= '0;
            r_count   <= '0;
            r_rcnt    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_seq     <= 1'b0;
        end else if (clr) begin
            r_state   <= ST_IDLE;
            r_wptr    <= '0;
            r_raddr   <= '0;
            r_count   <= '0;
            r_rcnt    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_seq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wptr    <= w_wptr_nxt;
            r_raddr   <= w_raddr_nxt;
            r_count   <= w_count_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
            r_seq     <= w_rd_en;
        end
    end

    dp_ram_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (new_smpl),
        .i_re    (w_rd_en),
        .i_raddr (r_raddr),
        .o_rdata (w_rdata)
    );

    assign sequencing = r_seq;
    assign smpl_out   = r_seq ? w_rdata : '0;
    assign primed     = (r_count >= c_SEQ_CNT);
    assign full       = (r_count == c_DEPTH_CNT);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/circ_buf_seq.md
Name: circ_buf_seq

Overview:
Parametrised circular sample buffer for the audio-filter datapath, built on a dual-port RAM. It stores incoming samples in a ring of DEPTH entries. On each accepted write, once at least SEQ_LEN samples are held, it streams the newest SEQ_LEN samples oldest-first, one per clock, flagged by `sequencing`. It feeds the FIR MAC engine and replaces the fixed-size, clock-divided buffer with a strobe-driven one that adds flush, overrun detection and back-to-back sequencing.

Parameters:
- DATA_W, 16, sample width in bits.
- DEPTH, 1536, ring size in samples; must be greater than SEQ_LEN.
- SEQ_LEN, 1021, samples streamed per sequence; must be at least 2.
- ADDR_W, $clog2(DEPTH), localparam, RAM address width.
- CNT_W, $clog2(DEPTH+1), localparam, fill-count width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous flush of pointers, count, sequence and overrun.
- wrt_smpl  input  1  one-cycle strobe: write new_smpl this cycle.
- new_smpl  input  DATA_W  sample to store.
- smpl_out  output  DATA_W  streamed sample, valid when sequencing=1.
- sequencing  output  1  smpl_out holds a valid window sample.
- primed  output  1  fill count >= SEQ_LEN.
- full  output  1  fill count == DEPTH.
- overrun  output  1  sticky: a write strobe was lost for sequencing purposes.

Behaviour:
- Reset (rst_n=0, async): wptr=0, count=0, state=IDLE, pending=0, overrun=0, sequencing=0, primed=0, full=0, smpl_out=0.
- Write path: on wrt_smpl=1 (and clr=0), RAM[wptr] <= new_smpl.
  - wptr <= (wptr==DEPTH-1) ? 0 : wptr+1.
  - count saturates at DEPTH.
  - Writes are accepted in every state, including during a sequence.
- Write during a sequence is safe: it lands at (start+SEQ_LEN) mod DEPTH, outside the active window, because DEPTH > SEQ_LEN.
- Trigger: a write is a trigger if the post-write count >= SEQ_LEN. A post-write count < SEQ_LEN never triggers.
- FSM states:
  - IDLE → SEQ on a trigger this cycle, or when pending=1.
    - Latch start = (wptr_after_write − SEQ_LEN) mod DEPTH.
    - Clear pending.
  - SEQ: issue a RAM read at raddr each cycle, with raddr wrapping DEPTH-1→0 and an issued-read counter.
    - After SEQ_LEN reads → IDLE.
- Triggers arriving while in SEQ:
  - In SEQ with pending=0: set pending=1.
  - In SEQ with pending=1: set overrun=1. The write itself still happens; only the extra sequence is dropped.
- Pending sequence: the window is computed from wptr at IDLE entry, so it always covers the newest SEQ_LEN samples.
- RAM: synchronous read, 1-cycle latency.
  - sequencing is the read-enable delayed by one register.
  - smpl_out = sequencing ? rdata : 0.
- Latency: for a write strobe sampled at edge T in IDLE, the SEQ read issue begins at edge T+1. sequencing=1 for exactly SEQ_LEN cycles, edges T+2..T+SEQ_LEN+1, with smpl_out = window samples oldest→newest.
- Back-to-back: with pending set, the FSM spends exactly one cycle in IDLE. sequencing is low for exactly one cycle between sequences.
- clr=1 (priority over wrt_smpl, whose sample is discarded):
  - wptr=0, count=0, state=IDLE, pending=0, overrun=0.
  - sequencing=0 from the next cycle.
  - RAM contents are left as-is but are unreachable until refilled.
- Async reset mid-sequence: outputs drop immediately. No sequencing until SEQ_LEN new samples are written.
- primed and full are combinational from the registered count.

Decomposition:
- Shared package holds buffer width/depth defaults, state encoding (IDLE, SEQ), and the wrap-increment helper function for pointers.
- One sub-module, dp_ram_sync: DEPTH×DATA_W, one write port, one synchronous-read port, no reset.
- Pointer, count and FSM logic stay in circ_buf_seq.

Test Plan:
All scenarios use DATA_W=16, DEPTH=8, SEQ_LEN=5, with writes spaced 10 cycles apart unless stated.
1. Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously; hold 3 cycles, release → still 0.
2. Priming: write 0x0001..0x0004 → sequencing never high, primed=0. Write 0x0005 at edge T → sequencing high edges T+2..T+6, smpl_out 1,2,3,4,5, primed=1, full=0.
3. Wrap and full: write 0x0001..0x000C → full=1 after the 8th write. After the 12th write the stream is 8,9,A,B,C, read from addresses 7,0,1,2,3.
4. Write during sequence: after the 5th write, write 0x0006 two cycles into the stream → first stream 1..5, one-cycle gap, second stream 2..6, overrun=0.
5. Overrun: two extra writes (0x0006, 0x0007) during one stream → overrun=1 and sticky. Next stream is 3..7, and no third stream follows.
6. Flush: assert clr during a stream → sequencing=0 next cycle, overrun=0, primed=0. Four new writes give no stream; the fifth streams only the new samples.
